double_buffer_ctrl: RTL and testbench
=====================================

// Module: double_buffer_ctrl
// PURPOSE
//  Ping-pong controller between the AXI write-data (DMA) channel and two blocking_buffer_slv instances.
//  Grants the two buffers in strict alternation and routes W-channel valid/ready to the loading buffer.
//  Muxes the pushing buffer's row data into one registered row stream for the systolic array.
//  Checks that push order matches grant order and flags violations.
// PARAMETERS
//  AXI_DW_g  64  data width of buffer rows and of row_data_o
//  depth_g   16  rows per matrix (per buffer fill); row_idx_o width = $clog2(depth_g)
// PORTS
//  clk_i           in   1         clock, single domain
//  rst_n_i         in   1         asynchronous active-low reset
//  enable_i        in   1         1 = new grants may be issued; 0 = finish current load, then hold
//  s_axi_wvalid_i  in   1         DMA W-channel valid
//  s_axi_wready_o  out  1         W-channel ready, taken from the loading buffer
//  buf_wvalid_o    out  2         per-buffer wvalid (bit n -> buffer n)
//  buf_wready_i    in   2         per-buffer s_axi_wready_o
//  buf_avail_i     in   2         per-buffer available_o
//  buf_push_i      in   2         per-buffer pushing_o
//  buf_data_i      in   2*DW      buffer n data_o at [n*DW +: DW]
//  buf_grant_o     out  2         one-cycle grant pulse per buffer
//  row_valid_o     out  1         row_data_o holds a valid row this cycle
//  row_data_o      out  DW        row to systolic array
//  row_idx_o       out  clog2(d)  index of current row within its matrix (0..depth_g-1)
//  matrix_done_o   out  1         pulse with the last valid row of a matrix
//  order_err_o     out  1         sticky: push order violated or both buffers pushing at once
// BEHAVIOUR
//  Reset (async): state=IDLE, ld_sel=0, rd_sel=0; all outputs 0 (row_data_o=0, order_err_o=0).
//  Load FSM, states IDLE, GRANT, LOADING:
//   IDLE: if enable_i && buf_avail_i[ld_sel] -> GRANT; else stay.
//   GRANT: buf_grant_o[ld_sel]=1 for exactly this cycle -> LOADING.
//   LOADING: when buf_avail_i[ld_sel]==0 (buffer full) -> ld_sel toggles, -> IDLE.
//   Never more than one grant bit high; no grant while LOADING.
//  W routing (combinational): in LOADING, buf_wvalid_o[ld_sel]=s_axi_wvalid_i and
//   s_axi_wready_o=buf_wready_i[ld_sel]; other bit and all cases outside LOADING drive 0.
//  Read path: BRAM read latency is 1 cycle, so data for a push cycle arrives the next cycle.
//   push_d = buf_push_i[rd_sel] registered; row_valid_o = push_d registered path:
//   row_data_o <= buf_data_i[rd_sel] and row_valid_o <= push_d (total 2 cycles pushing->row).
//   row_idx_o increments on each valid row, wraps to 0 after depth_g-1, resets to 0 at matrix end.
//   Matrix ends when push_d falls (valid row count = cycles pushing was high); matrix_done_o pulses
//   with that last row; rd_sel toggles at that same edge.
//  Error: buf_push_i[~rd_sel] high while rd_sel's matrix not started, or buf_push_i==2'b11
//   -> order_err_o set, held until reset; data path keeps following rd_sel.
//  Simultaneous: load switch and read switch on the same cycle are independent; both proceed.
//  enable_i low during LOADING: load completes normally, no further grant until enable_i high.
//  Reset mid-load/mid-push: all state cleared immediately; buffers are reset by same rst_n_i.
// TESTING
//  Reset, enable_i=1, buf_avail_i=2'b11 -> buf_grant_o=2'b01 exactly 2 cycles after reset release.
//  Buffer0 loading, s_axi_wvalid_i=1, buf_wready_i=2'b01 -> buf_wvalid_o=2'b01, s_axi_wready_o=1.
//  buf_avail_i[0] falls -> next grant is 2'b10 only; no second pulse on bit 0.
//  buf_push_i[0] high 16 cycles, data=row# -> 16 rows idx 0..15, data 0..15, done on idx 15.
//  Back-to-back: buf0 push then buf1 push next cycle -> 32 contiguous valid rows, idx wraps 15->0.
//  buf_push_i=2'b10 while rd_sel=0 -> order_err_o=1 and stays 1 until rst_n_i low.

Source files
------------

// File: rtl/double_buffer_ctrl.sv
// Ping-pong controller between the DMA write channel and two blocking buffers:
// alternating grants and W routing on the load side, one registered row stream on the read side.
module double_buffer_ctrl #(
  parameter int AXI_DW_g = 64,
  parameter int depth_g  = 16,
  localparam int IDX_W   = (depth_g > 1) ? $clog2(depth_g) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  s_axi_wvalid_i,
  output logic                  s_axi_wready_o,
  output logic [1:0]            buf_wvalid_o,
  input  logic [1:0]            buf_wready_i,
  input  logic [1:0]            buf_avail_i,
  input  logic [1:0]            buf_push_i,
  input  logic [2*AXI_DW_g-1:0] buf_data_i,
  output logic [1:0]            buf_grant_o,
  output logic                  row_valid_o,
  output logic [AXI_DW_g-1:0]   row_data_o,
  output logic [IDX_W-1:0]      row_idx_o,
  output logic                  matrix_done_o,
  output logic                  order_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOADING
  } state_t;

  state_t state_q, state_d;
  logic   ld_sel_q, ld_sel_d;

  // ---------------------------------------------------------------- load side
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      ld_sel_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      ld_sel_q <= ld_sel_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d        = state_q;
    ld_sel_d       = ld_sel_q;
    buf_grant_o    = '0;
    buf_wvalid_o   = '0;
    s_axi_wready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && buf_avail_i[ld_sel_q]) state_d = GRANT;
      end
      GRANT: begin
        buf_grant_o[ld_sel_q] = 1'b1;
        state_d               = LOADING;
      end
      LOADING: begin
        buf_wvalid_o[ld_sel_q] = s_axi_wvalid_i;
        s_axi_wready_o         = buf_wready_i[ld_sel_q];
        // Buffer dropping available means it is full: hand over to the other one.
        if (!buf_avail_i[ld_sel_q]) begin
          ld_sel_d = ~ld_sel_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- read side
  logic                 rd_sel_q;
  logic                 push_d_q;
  logic                 push_fall;
  logic                 rd_sel_nx;
  logic                 err_set;
  logic [IDX_W-1:0]     idx_inc;
  logic [AXI_DW_g-1:0]  rd_data;

  // A matrix is one contiguous run of push cycles, so a falling push ends it.
  assign push_fall = push_d_q & ~buf_push_i[rd_sel_q];
  assign rd_sel_nx = rd_sel_q ^ push_fall;
  assign rd_data   = rd_sel_q ? buf_data_i[2*AXI_DW_g-1:AXI_DW_g] : buf_data_i[AXI_DW_g-1:0];
  assign idx_inc   = (row_idx_o == IDX_W'(depth_g - 1)) ? '0 : row_idx_o + IDX_W'(1);
  // push_d_q doubles as "current matrix started"; the other buffer may only
  // push once the current one has begun, and never both together.
  assign err_set   = (&buf_push_i) | (buf_push_i[~rd_sel_q] & ~push_d_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_sel_q      <= 1'b0;
      push_d_q      <= 1'b0;
      row_valid_o   <= 1'b0;
      row_data_o    <= '0;
      row_idx_o     <= '0;
      matrix_done_o <= 1'b0;
      order_err_o   <= 1'b0;
    end else begin
      rd_sel_q      <= rd_sel_nx;
      // Sampling with the next selector keeps back-to-back matrices contiguous.
      push_d_q      <= buf_push_i[rd_sel_nx];
      row_valid_o   <= push_d_q;
      row_data_o    <= rd_data;
      matrix_done_o <= push_fall;
      order_err_o   <= order_err_o | err_set;
      if (push_d_q && row_valid_o && !matrix_done_o) row_idx_o <= idx_inc;
      else                                           row_idx_o <= '0;
    end
  end

endmodule

// File: tb/tb_double_buffer_ctrl.sv
// Self-checking bench for double_buffer_ctrl: directed start-up/back-to-back traffic,
// then randomized load and push traffic checked against a behavioural model.
module tb_double_buffer_ctrl;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int IW    = 4;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            enable_i;
  logic            s_axi_wvalid_i;
  logic            s_axi_wready_o;
  logic [1:0]      buf_wvalid_o;
  logic [1:0]      buf_wready_i;
  logic [1:0]      buf_avail_i;
  logic [1:0]      buf_push_i;
  logic [2*DW-1:0] buf_data_i;
  logic [1:0]      buf_grant_o;
  logic            row_valid_o;
  logic [DW-1:0]   row_data_o;
  logic [IW-1:0]   row_idx_o;
  logic            matrix_done_o;
  logic            order_err_o;

  always #5 clk_i = ~clk_i;

  double_buffer_ctrl #(.AXI_DW_g(DW), .depth_g(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .enable_i       (enable_i),
    .s_axi_wvalid_i (s_axi_wvalid_i),
    .s_axi_wready_o (s_axi_wready_o),
    .buf_wvalid_o   (buf_wvalid_o),
    .buf_wready_i   (buf_wready_i),
    .buf_avail_i    (buf_avail_i),
    .buf_push_i     (buf_push_i),
    .buf_data_i     (buf_data_i),
    .buf_grant_o    (buf_grant_o),
    .row_valid_o    (row_valid_o),
    .row_data_o     (row_data_o),
    .row_idx_o      (row_idx_o),
    .matrix_done_o  (matrix_done_o),
    .order_err_o    (order_err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  typedef struct {
    int          buf_i;
    int          idx;
    logic [63:0] data;
    bit          done;
    int          due;
  } row_t;

  int   m_loading;   // buffer currently being filled, -1 when none
  int   m_next;      // buffer that receives the next grant
  bit   m_pending;   // a grant is being shown this cycle
  int   m_rd;        // buffer whose matrix is being streamed out
  bit   m_active;    // that buffer's matrix has started
  int   m_idx;
  bit   m_err;
  row_t q[$];
  int   cyc;

  // push generator: alternating runs with random length and gap
  int g_buf, g_left, g_gap;
  int done_cnt;

  always @(negedge clk_i) if (matrix_done_o === 1'b1) done_cnt++;

  task automatic model_reset();
    m_loading = -1; m_next = 0; m_pending = 0;
    m_rd = 0; m_active = 0; m_idx = 0; m_err = 0;
    q.delete();
    cyc = 0;
    g_buf = 0; g_left = 0; g_gap = 0;
  endtask

  task automatic gen_push(output logic [1:0] p);
    p = '0;
    if (g_left == 0 && g_gap > 0) begin
      g_gap--;
    end else begin
      if (g_left == 0) g_left = $urandom_range(1, 20);
      p[g_buf] = 1'b1;
      g_left--;
      if (g_left == 0) begin
        g_buf = 1 - g_buf;
        g_gap = $urandom_range(0, 3);
      end
    end
  endtask

  // Called at a negedge: drives one cycle of inputs, checks outputs, advances the model.
  task automatic run_cycle(input bit en, input logic [1:0] avail, input bit wv,
                           input logic [1:0] wr, input logic [1:0] push,
                           input logic [63:0] d0, input logic [63:0] d1);
    logic [1:0] exp_grant, exp_wv;
    bit         exp_wr;
    row_t       r;
    enable_i = en; buf_avail_i = avail; s_axi_wvalid_i = wv; buf_wready_i = wr;
    buf_push_i = push; buf_data_i = {d1, d0};
    #1;
    exp_grant = '0; exp_wv = '0; exp_wr = 1'b0;
    if (m_pending) exp_grant[m_next] = 1'b1;
    if (m_loading >= 0) begin
      exp_wv[m_loading] = wv;
      exp_wr            = wr[m_loading];
    end
    check("grant", buf_grant_o, exp_grant);
    check("buf_wvalid", buf_wvalid_o, exp_wv);
    check("wready", s_axi_wready_o, exp_wr);
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      check("row_valid", row_valid_o, 1);
      check("row_data", row_data_o, r.data);
      check("row_idx", row_idx_o, r.idx);
      check("matrix_done", matrix_done_o, r.done);
    end else begin
      check("row_valid_idle", row_valid_o, 0);
      check("matrix_done_idle", matrix_done_o, 0);
    end
    check("order_err", order_err_o, m_err);

    // load side
    if (m_pending) begin
      m_loading = m_next;
      m_pending = 0;
    end else if (m_loading >= 0) begin
      if (!avail[m_loading]) begin
        m_next    = 1 - m_loading;
        m_loading = -1;
      end
    end else if (en && avail[m_next]) begin
      m_pending = 1;
    end
    // read side
    if (push == 2'b11 || (push[1-m_rd] && !m_active)) m_err = 1;
    foreach (q[i]) if (q[i].due == cyc + 1) q[i].data = (q[i].buf_i == 1) ? d1 : d0;
    if (m_active && !push[m_rd]) begin
      q[q.size()-1].done = 1;
      m_rd  = 1 - m_rd;
      m_idx = 0;
    end
    m_active = push[m_rd];
    if (m_active) begin
      q.push_back('{buf_i: m_rd, idx: m_idx, data: 64'h0, done: 1'b0, due: cyc + 2});
      m_idx = (m_idx + 1) % DEPTH;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    enable_i = 0; s_axi_wvalid_i = 0; buf_wready_i = '0; buf_avail_i = '0;
    buf_push_i = '0; buf_data_i = '0;
    #1;
    check("rst_grant", buf_grant_o, 0);
    check("rst_wvalid", buf_wvalid_o, 0);
    check("rst_wready", s_axi_wready_o, 0);
    check("rst_row_valid", row_valid_o, 0);
    check("rst_row_data", row_data_o, 0);
    check("rst_row_idx", row_idx_o, 0);
    check("rst_done", matrix_done_o, 0);
    check("rst_err", order_err_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    logic [1:0] p;
    for (int i = 0; i < n; i++) begin
      gen_push(p);
      run_cycle(($urandom_range(0, 9) != 0),
                {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                $urandom_range(0, 1), 2'($urandom_range(0, 3)), p,
                {$urandom, $urandom}, {$urandom, $urandom});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] p;
    rst_n_i = 1'b0;
    enable_i = 0; s_axi_wvalid_i = 0; buf_wready_i = '0; buf_avail_i = '0;
    buf_push_i = '0; buf_data_i = '0;
    do_reset();

    // Start-up grant, then a 16-row matrix from buffer 0 immediately followed by buffer 1.
    done_cnt = 0;
    run_cycle(1, 2'b11, 0, 2'b00, 2'b00, 64'h0, 64'h0);
    check("grant_after_reset", buf_grant_o, 2'b01);
    for (int k = 0; k < 36; k++) begin
      p = (k < 16) ? 2'b01 : (k < 32) ? 2'b10 : 2'b00;
      run_cycle(1, (k < 6) ? 2'b11 : 2'b10, 1, 2'b01, p,
                64'(k - 1), 64'(k - 1));
    end
    check("done_pulses_back_to_back", done_cnt, 2);

    random_cycles(2000);

    // Reset in the middle of traffic, then more random traffic.
    do_reset();
    random_cycles(600);

    // Buffer 1 pushing while buffer 0's matrix has not started.
    do_reset();
    run_cycle(0, 2'b00, 0, 2'b00, 2'b10, 64'h0, 64'h0);
    for (int k = 0; k < 4; k++) run_cycle(0, 2'b00, 0, 2'b00, 2'b00, 64'h0, 64'h0);
    check("err_sticky", order_err_o, 1);

    // Both buffers pushing at once.
    do_reset();
    run_cycle(0, 2'b00, 0, 2'b00, 2'b11, 64'h0, 64'h0);
    for (int k = 0; k < 3; k++) run_cycle(0, 2'b00, 0, 2'b00, 2'b00, 64'h0, 64'h0);
    check("err_both_push", order_err_o, 1);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
